tdm_demux8: RTL and testbench

// - Receive-side partner of the 8:1 mux: a time-division 1:8 demultiplexer.
// - Takes a serial stream of W-bit samples, one lane per slot, slot 0 first.

---
 rtl/tdm_demux8_pkg.sv | 15 +
 rtl/tdm_slot_ctr.sv | 48 ++++
 rtl/tdm_demux8.sv | 107 ++++++++++
 tb/tb_tdm_demux8.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux8_pkg.sv
// Shared definitions for the TDM link (demultiplexer and matching transmitter).
// Holds the default frame geometry and the FSM state encodings so both ends
// of the link agree on them.
package tdm_demux8_pkg;

    // Default frame geometry: LANES slots, SEL_W = log2(LANES) bit slot index.
    localparam int TDM_LANES = 8;
    localparam int TDM_SEL_W = 3;

    // FSM state encodings, kept as plain constants so older code can share them.
    typedef logic [0:0] tdm_state_t;
    localparam tdm_state_t ST_IDLE    = 1'b0;
    localparam tdm_state_t ST_COLLECT = 1'b1;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the TDM demultiplexer.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (sel -> 0)
//   i_clear  force sel to 0 (frame completed)
//   i_load1  force sel to 1 (slot 0 was just taken)
//   i_inc    advance to the next slot, wrapping LANES-1 -> 0
//   o_sel    current slot index
//   o_last   high when o_sel == LANES-1
module tdm_slot_ctr
    import tdm_demux8_pkg::*;
#(
    parameter int LANES = TDM_LANES,
    parameter int SEL_W = TDM_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load1,
    input  logic             i_inc,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_last
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);

    logic [SEL_W-1:0] r_sel;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sel <= '0;
        end else if (i_load1) begin
            r_sel <= SEL_W'(1);
        end else if (i_inc) begin
            // Wrap is spelled out rather than relying on counter overflow,
            // so non-power-of-two experiments still behave.
            if (r_sel == LAST_SLOT) begin
                r_sel <= '0;
            end else begin
                r_sel <= r_sel + SEL_W'(1);
            end
        end
    end

    assign o_sel  = r_sel;
    assign o_last = (r_sel == LAST_SLOT);

endmodule

// File: rtl/tdm_demux8.sv
// Time-division 1:LANES demultiplexer: rebuilds a serial stream of W-bit
// samples (slot 0 first, marked by frame_sync) into a parallel word.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   din         serial sample for the current slot
//   din_valid   din is valid this cycle
//   frame_sync  marks slot 0; only looked at when din_valid=1
//   sel         current slot index
//   y           last complete frame, lane k at y[k*W +: W]
//   y_valid     one-cycle pulse: y updated
//   sync_err    one-cycle pulse: partial frame dropped by an early sync
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for frame_sync; unsynced samples are dropped
// ST_COLLECT | slots 1..LANES-1 being gathered into the shadow register
module tdm_demux8
    import tdm_demux8_pkg::*;
#(
    parameter int LANES = TDM_LANES,
    parameter int SEL_W = TDM_SEL_W,
    parameter int W     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       din,
    input  logic               din_valid,
    input  logic               frame_sync,
    output logic [SEL_W-1:0]   sel,
    output logic [LANES*W-1:0] y,
    output logic               y_valid,
    output logic               sync_err
);

    tdm_state_t               r_state;
    // Only lanes 0..LANES-2 need storing: the final lane comes straight
    // from din in the cycle the frame completes.
    logic [(LANES-1)*W-1:0]   r_shadow;
    logic [LANES*W-1:0]       r_y;
    logic                     r_y_valid;
    logic                     r_sync_err;

    logic                     w_start;
    logic                     w_sample;
    logic                     w_last;
    logic                     w_done;
    logic [SEL_W-1:0]         w_sel;
    logic [LANES*W-1:0]       w_frame;

    // A sync always restarts the frame, even on the last slot.
    assign w_start  = din_valid && frame_sync;
    assign w_sample = din_valid && !frame_sync && (r_state == ST_COLLECT);
    assign w_done   = w_sample && w_last;
    assign w_frame  = {din, r_shadow};

    tdm_slot_ctr #(
        .LANES (LANES),
        .SEL_W (SEL_W)
    ) u_slot_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_done),
        .i_load1 (w_start),
        .i_inc   (w_sample && !w_last),
        .o_sel   (w_sel),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shadow   <= '0;
            r_y        <= '0;
            r_y_valid  <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_y_valid  <= 1'b0;
            r_sync_err <= 1'b0;
            if (w_start) begin
                r_shadow[0 +: W] <= din;
                r_state          <= ST_COLLECT;
                // Sync while collecting means the partial frame is lost.
                if (r_state == ST_COLLECT) begin
                    r_sync_err <= 1'b1;
                end
            end else if (w_sample) begin
                for (int k = 1; k < LANES - 1; k++) begin
                    if (w_sel == SEL_W'(k)) begin
                        r_shadow[k*W +: W] <= din;
                    end
                end
                if (w_last) begin
                    r_y       <= w_frame;
                    r_y_valid <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            end
        end
    end

    assign sel      = w_sel;
    assign y        = r_y;
    assign y_valid  = r_y_valid;
    assign sync_err = r_sync_err;

endmodule

// File: tb/tb_tdm_demux8.sv
module tb_tdm_demux8;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [2:0] sel;
    logic [7:0] y;
    logic       y_valid;
    logic       sync_err;

    int n_tests = 0;
    int n_fail  = 0;

    tdm_demux8 dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .sel        (sel),
        .y          (y),
        .y_valid    (y_valid),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid sample for one cycle, then return the bus to idle.
    task automatic send(input logic d, input logic s);
        din        = d;
        din_valid  = 1'b1;
        frame_sync = s;
        tick();
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b1; din_valid = 1'b1; frame_sync = 1'b1;
        tick();
        tick();
        rst = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; din = 1'b0;
        n_tests++;
        if (y !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h want 00", y); end
        n_tests++;
        if (sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel); end
        n_tests++;
        if (y_valid !== 1'b0 || sync_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: got y_valid=%b sync_err=%b want 0 0", y_valid, sync_err);
        end
    endtask

    task automatic test_clean_frame();
        logic [7:0] pat;
        pat = 8'hFA;
        for (int k = 0; k < 8; k++) begin
            send(pat[k], k == 0);
            if (k < 7) begin
                n_tests++;
                if (y_valid !== 1'b0 || sel !== 3'(k + 1)) begin
                    n_fail++;
                    $display("FAIL clean_mid slot %0d: got y_valid=%b sel=%0d want 0 %0d", k, y_valid, sel, k + 1);
                end
            end
        end
        n_tests++;
        if (y_valid !== 1'b1 || y !== 8'hFA) begin
            n_fail++; $display("FAIL clean_done: got y_valid=%b y=%h want 1 FA", y_valid, y);
        end
        n_tests++;
        if (sel !== 3'd0) begin n_fail++; $display("FAIL clean_sel_wrap: got %0d want 0", sel); end
        tick();
        n_tests++;
        if (y_valid !== 1'b0 || y !== 8'hFA) begin
            n_fail++; $display("FAIL clean_pulse_width: got y_valid=%b y=%h want 0 FA", y_valid, y);
        end
    endtask

    task automatic test_gapped_frame();
        logic [7:0] pat;
        pat = 8'hFA;
        // Make sure a stale y from the previous test cannot satisfy the check.
        for (int k = 0; k < 8; k++) send(1'b0, k == 0);
        n_tests++;
        if (y !== 8'h00) begin n_fail++; $display("FAIL gap_preclear: got %h want 00", y); end
        for (int k = 0; k < 4; k++) send(pat[k], k == 0);
        for (int g = 0; g < 3; g++) begin
            tick();
            n_tests++;
            if (sel !== 3'd4 || y_valid !== 1'b0) begin
                n_fail++; $display("FAIL gap_hold %0d: got sel=%0d y_valid=%b want 4 0", g, sel, y_valid);
            end
        end
        for (int k = 4; k < 8; k++) send(pat[k], 1'b0);
        n_tests++;
        if (y_valid !== 1'b1 || y !== 8'hFA) begin
            n_fail++; $display("FAIL gap_done: got y_valid=%b y=%h want 1 FA", y_valid, y);
        end
    endtask

    task automatic test_early_sync();
        int errs;
        errs = 0;
        // Slots 0..4 of a frame, then a sync arrives in slot 5.
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            send(1'b1, k == 0);
            if (sync_err === 1'b1) errs++;
            if (k == 0) begin
                n_tests++;
                if (sync_err !== 1'b1 || sel !== 3'd1) begin
                    n_fail++; $display("FAIL early_err: got sync_err=%b sel=%0d want 1 1", sync_err, sel);
                end
            end
            if (k < 7) begin
                n_tests++;
                if (y !== 8'hFA || y_valid !== 1'b0) begin
                    n_fail++; $display("FAIL early_y_hold %0d: got y=%h y_valid=%b want FA 0", k, y, y_valid);
                end
            end
        end
        n_tests++;
        if (y_valid !== 1'b1 || y !== 8'hFF || sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL early_done: got y_valid=%b y=%h sync_err=%b want 1 FF 0", y_valid, y, sync_err);
        end
        n_tests++;
        if (errs != 1) begin n_fail++; $display("FAIL early_err_count: got %0d want 1", errs); end
        tick();
    endtask

    task automatic test_early_sync_last_slot();
        // Sync on slot 7: the restart wins, no frame completes.
        for (int k = 0; k < 7; k++) send(1'b0, k == 0);
        send(1'b0, 1'b1);
        n_tests++;
        if (sync_err !== 1'b1 || y_valid !== 1'b0 || y !== 8'hFF || sel !== 3'd1) begin
            n_fail++;
            $display("FAIL last_slot_sync: got sync_err=%b y_valid=%b y=%h sel=%0d want 1 0 FF 1",
                     sync_err, y_valid, y, sel);
        end
        for (int k = 1; k < 8; k++) send(1'b0, 1'b0);
        n_tests++;
        if (y_valid !== 1'b1 || y !== 8'h00) begin
            n_fail++; $display("FAIL last_slot_recover: got y_valid=%b y=%h want 1 00", y_valid, y);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat;
        int          pulse_at [2];
        logic [7:0]  pulse_y  [2];
        int          npulse;
        int          nerr;
        int          both;
        pat    = {8'h3C, 8'hA5};
        npulse = 0; nerr = 0; both = 0;
        pulse_at[0] = -1; pulse_at[1] = -1;
        pulse_y[0]  = 8'h00; pulse_y[1] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            send(pat[i], (i % 8) == 0);
            if (sync_err === 1'b1) nerr++;
            if (sync_err === 1'b1 && y_valid === 1'b1) both++;
            if (y_valid === 1'b1) begin
                if (npulse < 2) begin
                    pulse_at[npulse] = i;
                    pulse_y[npulse]  = y;
                end
                npulse++;
            end
        end
        n_tests++;
        if (npulse != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", npulse); end
        n_tests++;
        if (pulse_at[0] != 7 || pulse_at[1] != 15) begin
            n_fail++; $display("FAIL b2b_timing: got %0d,%0d want 7,15", pulse_at[0], pulse_at[1]);
        end
        n_tests++;
        if (pulse_y[0] !== 8'hA5 || pulse_y[1] !== 8'h3C) begin
            n_fail++; $display("FAIL b2b_data: got %h,%h want A5,3C", pulse_y[0], pulse_y[1]);
        end
        n_tests++;
        if (nerr != 0 || both != 0) begin
            n_fail++; $display("FAIL b2b_sync_err: got %0d errs %0d overlaps want 0 0", nerr, both);
        end
        tick();
    endtask

    task automatic test_stray_and_reset();
        for (int k = 0; k < 3; k++) begin
            send(1'b1, 1'b0);
            n_tests++;
            if (sel !== 3'd0 || y_valid !== 1'b0) begin
                n_fail++; $display("FAIL stray %0d: got sel=%0d y_valid=%b want 0 0", k, sel, y_valid);
            end
        end
        for (int k = 0; k < 4; k++) send(1'b1, k == 0);
        n_tests++;
        if (sel !== 3'd4) begin n_fail++; $display("FAIL midrst_pre: got sel=%0d want 4", sel); end
        rst = 1'b1; din = 1'b1; din_valid = 1'b1; frame_sync = 1'b0;
        tick();
        rst = 1'b0; din_valid = 1'b0; din = 1'b0;
        n_tests++;
        if (sel !== 3'd0 || y !== 8'h00 || sync_err !== 1'b0 || y_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: got sel=%0d y=%h sync_err=%b y_valid=%b want 0 00 0 0",
                     sel, y, sync_err, y_valid);
        end
        // Back in IDLE: the remaining slots of the dead frame are dropped.
        for (int k = 4; k < 8; k++) send(1'b1, 1'b0);
        n_tests++;
        if (sel !== 3'd0 || y_valid !== 1'b0 || y !== 8'h00) begin
            n_fail++; $display("FAIL midrst_tail: got sel=%0d y_valid=%b y=%h want 0 0 00", sel, y_valid, y);
        end
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
        test_reset();
        test_clean_frame();
        test_gapped_frame();
        test_early_sync();
        test_early_sync_last_slot();
        test_back_to_back();
        test_stray_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
